cv32e40x_txn_tracker: RTL and testbench

CV32E40X_TXN_TRACKER -- requirements
Module: cv32e40x_txn_tracker

---
 rtl/cv32e40x_txn_tracker.sv | 90 +++++++++
 tb/tb_cv32e40x_txn_tracker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_txn_tracker.sv
// Outstanding-transaction tracker between the core LSU and the alignment checker.
// Counts in-flight requests, keeps their write/read tags in order, and flags stray responses.
module cv32e40x_txn_tracker #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       core_trans_valid_i,
  input  logic                       core_trans_we_i,
  output logic                       core_trans_ready_o,
  output logic                       down_trans_valid_o,
  input  logic                       down_trans_ready_i,
  input  logic                       resp_valid_i,
  output logic                       resp_valid_o,
  output logic                       resp_we_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o,
  output logic                       one_txn_pend_n_o,
  output logic                       full_o,
  output logic                       resp_err_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_tags [DEPTH];

  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_retire;
  logic [CNT_W-1:0] w_cnt_n;

  // Pointers wrap explicitly so non-power-of-two depths never index past the tag store.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign w_full   = (r_cnt == CNT_W'(DEPTH));
  assign w_empty  = (r_cnt == '0);
  assign w_accept = core_trans_valid_i && down_trans_ready_i && !w_full;
  assign w_retire = resp_valid_i && !w_empty;

  // A response in the same cycle as an accept only ever retires an older entry.
  always_comb begin
    // NOTE: default first so every path assigns w_cnt_n; otherwise a latch is inferred.
    w_cnt_n = r_cnt;
    if (rst) begin
      w_cnt_n = '0;
    end else if (w_accept && !w_retire) begin
      w_cnt_n = r_cnt + CNT_W'(1);
    end else if (!w_accept && w_retire) begin
      w_cnt_n = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      // NOTE: the tag store is cleared on reset so stale tags can never reach resp_we_o.
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_tags[i] <= 1'b0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_cnt <= w_cnt_n;
      if (w_accept) begin
        r_tags[r_wr_ptr] <= core_trans_we_i;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_retire) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end
  end

  assign core_trans_ready_o = down_trans_ready_i && !w_full;
  assign down_trans_valid_o = core_trans_valid_i && !w_full;
  assign resp_valid_o       = resp_valid_i;
  assign resp_we_o          = w_empty ? 1'b0 : r_tags[r_rd_ptr];
  assign resp_err_o         = resp_valid_i && w_empty;
  assign cnt_o              = r_cnt;
  assign full_o             = w_full;
  assign one_txn_pend_n_o   = (w_cnt_n == CNT_W'(1));

endmodule

// File: tb/tb_cv32e40x_txn_tracker.sv
// Bench for cv32e40x_txn_tracker: DEPTH=2 and DEPTH=3 instances share stimulus and are
// checked against a queue model of outstanding tags.
module tb_cv32e40x_txn_tracker;

  typedef struct packed {
    logic       ready;
    logic       dvalid;
    logic       rvalid;
    logic       rwe;
    logic [1:0] cnt;
    logic       one;
    logic       full;
    logic       err;
  } obs_t;

  logic clk = 1'b0;
  logic rst, v, we, dr, rv;
  always #5 clk = ~clk;

  logic o2_ready, o2_dvalid, o2_rvalid, o2_rwe, o2_one, o2_full, o2_err;
  logic o3_ready, o3_dvalid, o3_rvalid, o3_rwe, o3_one, o3_full, o3_err;
  logic [1:0] o2_cnt, o3_cnt;
  obs_t obs2, obs3, e2, e3;

  bit q2[$];
  bit q3[$];
  int n_vec = 0;
  int n_err = 0;

  assign obs2 = {o2_ready, o2_dvalid, o2_rvalid, o2_rwe, o2_cnt, o2_one, o2_full, o2_err};
  assign obs3 = {o3_ready, o3_dvalid, o3_rvalid, o3_rwe, o3_cnt, o3_one, o3_full, o3_err};

  cv32e40x_txn_tracker #(.DEPTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .core_trans_valid_i(v), .core_trans_we_i(we), .core_trans_ready_o(o2_ready),
    .down_trans_valid_o(o2_dvalid), .down_trans_ready_i(dr),
    .resp_valid_i(rv), .resp_valid_o(o2_rvalid), .resp_we_o(o2_rwe),
    .cnt_o(o2_cnt), .one_txn_pend_n_o(o2_one), .full_o(o2_full), .resp_err_o(o2_err)
  );

  cv32e40x_txn_tracker #(.DEPTH(3)) dut3 (
    .clk(clk), .rst(rst),
    .core_trans_valid_i(v), .core_trans_we_i(we), .core_trans_ready_o(o3_ready),
    .down_trans_valid_o(o3_dvalid), .down_trans_ready_i(dr),
    .resp_valid_i(rv), .resp_valid_o(o3_rvalid), .resp_we_o(o3_rwe),
    .cnt_o(o3_cnt), .one_txn_pend_n_o(o3_one), .full_o(o3_full), .resp_err_o(o3_err)
  );

  function automatic obs_t predict(input int depth, input int size, input bit head,
                                   input bit p_rst, input bit p_v, input bit p_dr, input bit p_rv);
    obs_t o;
    bit   full;
    bit   acc;
    bit   ret;
    int   nxt;
    full     = (size == depth);
    acc      = p_v && p_dr && !full;
    ret      = p_rv && (size != 0);
    nxt      = p_rst ? 0 : size + int'(acc) - int'(ret);
    o.ready  = p_dr && !full;
    o.dvalid = p_v && !full;
    o.rvalid = p_rv;
    o.rwe    = (size != 0) ? head : 1'b0;
    o.cnt    = 2'(size);
    o.one    = (nxt == 1);
    o.full   = full;
    o.err    = p_rv && (size == 0);
    return o;
  endfunction

  // Drive one cycle of inputs, predict pre-edge outputs, then advance the scoreboard.
  task automatic apply(input bit a_rst, input bit a_v, input bit a_we, input bit a_dr, input bit a_rv);
    bit acc2, acc3, ret2, ret3;
    @(negedge clk);
    rst = a_rst; v = a_v; we = a_we; dr = a_dr; rv = a_rv;
    #1;
    e2   = predict(2, q2.size(), (q2.size() != 0) ? q2[0] : 1'b0, a_rst, a_v, a_dr, a_rv);
    e3   = predict(3, q3.size(), (q3.size() != 0) ? q3[0] : 1'b0, a_rst, a_v, a_dr, a_rv);
    acc2 = a_v && a_dr && (q2.size() < 2);
    acc3 = a_v && a_dr && (q3.size() < 3);
    ret2 = a_rv && (q2.size() != 0);
    ret3 = a_rv && (q3.size() != 0);
    if (a_rst) begin
      q2.delete();
      q3.delete();
    end else begin
      if (ret2) void'(q2.pop_front());
      if (ret3) void'(q3.pop_front());
      if (acc2) q2.push_back(a_we);
      if (acc3) q3.push_back(a_we);
    end
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 1, 0);
    apply(1, 0, 0, 1, 0);
    n_vec++; if (obs2 !== e2) begin n_err++; $display("FAIL reset_d2: got %b want %b", obs2, e2); end
    n_vec++; if (obs3 !== e3) begin n_err++; $display("FAIL reset_d3: got %b want %b", obs3, e3); end
    n_vec++; if (o2_cnt !== 2'd0 || o2_ready !== 1'b1 || o2_rwe !== 1'b0 || o2_one !== 1'b0)
      begin n_err++; $display("FAIL reset_outs: cnt=%0d ready=%b rwe=%b one=%b want 0 1 0 0", o2_cnt, o2_ready, o2_rwe, o2_one); end
    apply(0, 0, 0, 0, 0);
    n_vec++; if (o2_ready !== 1'b0 || o2_full !== 1'b0 || o2_err !== 1'b0)
      begin n_err++; $display("FAIL reset_idle: ready=%b full=%b err=%b want 0 0 0", o2_ready, o2_full, o2_err); end
  endtask

  task automatic test_fill();
    apply(0, 1, 1, 1, 0);
    n_vec++; if (obs2 !== e2) begin n_err++; $display("FAIL fill_w: got %b want %b", obs2, e2); end
    n_vec++; if (o2_one !== 1'b1) begin n_err++; $display("FAIL fill_w_one: got %b want 1", o2_one); end
    apply(0, 1, 0, 1, 0);
    n_vec++; if (o2_cnt !== 2'd1) begin n_err++; $display("FAIL fill_r_cnt: got %0d want 1", o2_cnt); end
    apply(0, 1, 1, 1, 0);
    n_vec++; if (o2_cnt !== 2'd2 || o2_full !== 1'b1 || o2_ready !== 1'b0 || o2_dvalid !== 1'b0)
      begin n_err++; $display("FAIL fill_full: cnt=%0d full=%b ready=%b dvalid=%b want 2 1 0 0", o2_cnt, o2_full, o2_ready, o2_dvalid); end
    n_vec++; if (obs3 !== e3) begin n_err++; $display("FAIL fill_d3: got %b want %b", obs3, e3); end
  endtask

  task automatic test_drain();
    apply(0, 0, 0, 1, 1);
    n_vec++; if (o2_rwe !== 1'b1 || o2_one !== 1'b1 || o2_rvalid !== 1'b1)
      begin n_err++; $display("FAIL drain_first: rwe=%b one=%b rvalid=%b want 1 1 1", o2_rwe, o2_one, o2_rvalid); end
    n_vec++; if (obs3 !== e3) begin n_err++; $display("FAIL drain_first_d3: got %b want %b", obs3, e3); end
    apply(0, 0, 0, 1, 1);
    n_vec++; if (o2_rwe !== 1'b0 || o2_cnt !== 2'd1 || o2_one !== 1'b0)
      begin n_err++; $display("FAIL drain_second: rwe=%b cnt=%0d one=%b want 0 1 0", o2_rwe, o2_cnt, o2_one); end
    apply(0, 0, 0, 1, 0);
    n_vec++; if (o2_cnt !== 2'd0) begin n_err++; $display("FAIL drain_empty: got %0d want 0", o2_cnt); end
    n_vec++; if (obs3 !== e3) begin n_err++; $display("FAIL drain_d3: got %b want %b", obs3, e3); end
  endtask

  task automatic test_same_cycle();
    apply(1, 0, 0, 1, 0);
    apply(0, 1, 1, 1, 0);
    apply(0, 1, 0, 1, 1);
    n_vec++; if (o2_cnt !== 2'd1 || o2_rwe !== 1'b1 || o2_err !== 1'b0 || o2_one !== 1'b1)
      begin n_err++; $display("FAIL same_cycle: cnt=%0d rwe=%b err=%b one=%b want 1 1 0 1", o2_cnt, o2_rwe, o2_err, o2_one); end
    apply(0, 0, 0, 1, 1);
    n_vec++; if (o2_cnt !== 2'd1 || o2_rwe !== 1'b0)
      begin n_err++; $display("FAIL same_cycle_order: cnt=%0d rwe=%b want 1 0", o2_cnt, o2_rwe); end
    apply(0, 0, 0, 1, 0);
    n_vec++; if (obs2 !== e2) begin n_err++; $display("FAIL same_cycle_end: got %b want %b", obs2, e2); end
  endtask

  task automatic test_error();
    apply(0, 0, 0, 1, 1);
    n_vec++; if (o2_err !== 1'b1 || o2_rvalid !== 1'b1 || o2_rwe !== 1'b0 || o2_cnt !== 2'd0)
      begin n_err++; $display("FAIL stray_resp: err=%b rvalid=%b rwe=%b cnt=%0d want 1 1 0 0", o2_err, o2_rvalid, o2_rwe, o2_cnt); end
    apply(0, 1, 1, 1, 1);
    n_vec++; if (o2_err !== 1'b1 || o2_one !== 1'b1)
      begin n_err++; $display("FAIL stray_with_accept: err=%b one=%b want 1 1", o2_err, o2_one); end
    apply(0, 1, 0, 1, 0);
    n_vec++; if (o2_cnt !== 2'd1 || o2_rwe !== 1'b1)
      begin n_err++; $display("FAIL accept_counted: cnt=%0d rwe=%b want 1 1", o2_cnt, o2_rwe); end
    apply(0, 1, 0, 1, 1);
    n_vec++; if (o2_full !== 1'b1 || o2_ready !== 1'b0 || o2_dvalid !== 1'b0 || o2_rwe !== 1'b1 || o2_err !== 1'b0)
      begin n_err++; $display("FAIL full_resp: full=%b ready=%b dvalid=%b rwe=%b err=%b want 1 0 0 1 0", o2_full, o2_ready, o2_dvalid, o2_rwe, o2_err); end
    n_vec++; if (obs3 !== e3) begin n_err++; $display("FAIL full_resp_d3: got %b want %b", obs3, e3); end
    apply(0, 1, 0, 1, 0);
    n_vec++; if (o2_ready !== 1'b1 || o2_cnt !== 2'd1 || o2_rwe !== 1'b0)
      begin n_err++; $display("FAIL ready_restored: ready=%b cnt=%0d rwe=%b want 1 1 0", o2_ready, o2_cnt, o2_rwe); end
  endtask

  task automatic test_wrap();
    apply(1, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      apply(0, 1, i[0], 1, 0);
      n_vec++; if (obs3 !== e3) begin n_err++; $display("FAIL wrap_acc_%0d: got %b want %b", i, obs3, e3); end
      apply(0, 0, 0, 1, 1);
      n_vec++; if (o3_rwe !== i[0] || o3_err !== 1'b0)
        begin n_err++; $display("FAIL wrap_tag_%0d: rwe=%b err=%b want %b 0", i, o3_rwe, o3_err, i[0]); end
      n_vec++; if (obs2 !== e2) begin n_err++; $display("FAIL wrap_d2_%0d: got %b want %b", i, obs2, e2); end
    end
  endtask

  task automatic test_reset_mid();
    apply(1, 0, 0, 1, 0);
    apply(0, 1, 1, 1, 0);
    apply(0, 1, 0, 1, 0);
    apply(0, 0, 0, 1, 0);
    n_vec++; if (o2_cnt !== 2'd2) begin n_err++; $display("FAIL pre_reset_cnt: got %0d want 2", o2_cnt); end
    apply(1, 0, 0, 1, 0);
    apply(0, 0, 0, 1, 0);
    n_vec++; if (o2_cnt !== 2'd0 || o2_full !== 1'b0 || o2_ready !== 1'b1)
      begin n_err++; $display("FAIL post_reset: cnt=%0d full=%b ready=%b want 0 0 1", o2_cnt, o2_full, o2_ready); end
    apply(0, 0, 0, 1, 1);
    n_vec++; if (o2_err !== 1'b1 || o2_rwe !== 1'b0)
      begin n_err++; $display("FAIL post_reset_resp: err=%b rwe=%b want 1 0", o2_err, o2_rwe); end
  endtask

  task automatic test_random();
    apply(1, 0, 0, 1, 0);
    for (int i = 0; i < 200; i++) begin
      apply(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      n_vec++; if (obs2 !== e2) begin n_err++; $display("FAIL rand_d2_%0d: got %b want %b", i, obs2, e2); end
      n_vec++; if (obs3 !== e3) begin n_err++; $display("FAIL rand_d3_%0d: got %b want %b", i, obs3, e3); end
    end
  endtask

  initial begin
    rst = 1'b1; v = 1'b0; we = 1'b0; dr = 1'b0; rv = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_same_cycle();
    test_error();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
